spi_slave_endpoint: RTL and testbench

// - SPI mode-0 slave endpoint that terminates the SPI_SCLK/SPI_CSN/SPI_MOSI/SPI_MISO link driven by the SPI master.
// - Oversamples the SPI pins on the system clock and deserialises MOSI into received words.
// - Serialises a loaded transmit word onto MISO, MSB first.
// - Replaces the free-toggling MISO stimulus in master-level benches and serves as the on-chip slave front end.

---
 rtl/spi_slave_endpoint.sv | 180 ++++++++++++++++++
 tb/tb_spi_slave_endpoint.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_endpoint.sv
// SPI mode-0 slave endpoint: oversamples SCLK/CSN/MOSI on clk, deserialises
// MOSI into words and serialises a held transmit word onto MISO, MSB first.
module spi_slave_endpoint #(
   parameter int DATA_W  = 8,
   parameter int SYNC_ST = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SPI_SCLK,
   input  logic              SPI_CSN,
   input  logic              SPI_MOSI,
   output logic              SPI_MISO,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_load,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy,
   output logic              tx_underrun,
   output logic              frame_err
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [SYNC_ST-1:0] r_sclk_sync;
   logic [SYNC_ST-1:0] r_csn_sync;
   logic [SYNC_ST-1:0] r_mosi_sync;
   logic               r_sclk_d;
   logic               r_csn_d;

   logic [DATA_W-1:0]  r_hold;
   logic               r_tx_fresh;
   logic [DATA_W-1:0]  r_shift_tx;
   logic [DATA_W-1:0]  r_shift_rx;
   logic [CNT_W-1:0]   r_bit_cnt;
   logic               r_reload_pend;
   logic [DATA_W-1:0]  r_rx_data;
   logic               r_rx_valid;
   logic               r_underrun;
   logic               r_frame_err;
   logic               r_miso;

   logic w_sclk_s, w_csn_s, w_mosi_s;
   logic w_sclk_rise, w_sclk_fall, w_csn_fall, w_csn_rise;
   logic w_start, w_rx_shift, w_word_done, w_tx_shift, w_frame_end;
   logic [DATA_W-1:0] w_shift_tx_nxt;
   logic [DATA_W-1:0] w_rx_word;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sclk_sync <= '0;
         r_csn_sync  <= '1;
         r_mosi_sync <= '0;
         r_sclk_d    <= 1'b0;
         r_csn_d     <= 1'b1;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_ST-2:0], SPI_SCLK};
         r_csn_sync  <= {r_csn_sync[SYNC_ST-2:0], SPI_CSN};
         r_mosi_sync <= {r_mosi_sync[SYNC_ST-2:0], SPI_MOSI};
         r_sclk_d    <= r_sclk_sync[SYNC_ST-1];
         r_csn_d     <= r_csn_sync[SYNC_ST-1];
      end
   end

   assign w_sclk_s    = r_sclk_sync[SYNC_ST-1];
   assign w_csn_s     = r_csn_sync[SYNC_ST-1];
   assign w_mosi_s    = r_mosi_sync[SYNC_ST-1];
   assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
   assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
   assign w_csn_fall  = ~w_csn_s & r_csn_d;
   assign w_csn_rise  = w_csn_s & ~r_csn_d;
   assign w_rx_word   = {r_shift_rx[DATA_W-2:0], w_mosi_s};

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // CSN rising wins over a coincident SCLK edge, so a master that releases
   // CSN together with the final SCLK fall ends the frame without a reload.
   always_comb begin
      w_state_nxt    = r_state;
      w_start        = 1'b0;
      w_rx_shift     = 1'b0;
      w_word_done    = 1'b0;
      w_tx_shift     = 1'b0;
      w_frame_end    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_csn_fall) begin
               w_state_nxt = ST_ACTIVE;
               w_start     = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (w_csn_rise) begin
               w_state_nxt = ST_IDLE;
               w_frame_end = 1'b1;
            end else begin
               if (w_sclk_rise) begin
                  w_rx_shift  = 1'b1;
                  w_word_done = (r_bit_cnt == LAST_BIT);
               end
               if (w_sclk_fall) begin
                  if (r_reload_pend) w_start    = 1'b1;
                  else               w_tx_shift = 1'b1;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      w_shift_tx_nxt = r_shift_tx;
      if (w_start)         w_shift_tx_nxt = tx_load ? tx_data : r_hold;
      else if (w_tx_shift) w_shift_tx_nxt = {r_shift_tx[DATA_W-2:0], 1'b0};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold        <= '0;
         r_tx_fresh    <= 1'b0;
         r_shift_tx    <= '0;
         r_shift_rx    <= '0;
         r_bit_cnt     <= '0;
         r_reload_pend <= 1'b0;
         r_rx_data     <= '0;
         r_rx_valid    <= 1'b0;
         r_underrun    <= 1'b0;
         r_frame_err   <= 1'b0;
         r_miso        <= 1'b0;
      end else begin
         r_rx_valid  <= 1'b0;
         r_underrun  <= 1'b0;
         r_frame_err <= 1'b0;
         r_shift_tx  <= w_shift_tx_nxt;
         r_miso      <= (w_state_nxt == ST_ACTIVE) & w_shift_tx_nxt[DATA_W-1];
         // A load landing on a word start goes straight out and is not fresh.
         if (w_start) begin
            r_underrun    <= ~r_tx_fresh & ~tx_load;
            r_tx_fresh    <= 1'b0;
            r_reload_pend <= 1'b0;
            r_bit_cnt     <= '0;
            if (tx_load) r_hold <= tx_data;
         end else if (tx_load) begin
            r_hold     <= tx_data;
            r_tx_fresh <= 1'b1;
         end
         if (w_frame_end) begin
            r_frame_err   <= (r_bit_cnt != '0);
            r_bit_cnt     <= '0;
            r_reload_pend <= 1'b0;
         end else if (w_rx_shift) begin
            r_shift_rx <= w_rx_word;
            if (w_word_done) begin
               r_rx_data     <= w_rx_word;
               r_rx_valid    <= 1'b1;
               r_bit_cnt     <= '0;
               r_reload_pend <= 1'b1;
            end else begin
               r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign SPI_MISO    = r_miso;
   assign rx_data     = r_rx_data;
   assign rx_valid    = r_rx_valid;
   assign busy        = ~w_csn_s;
   assign tx_underrun = r_underrun;
   assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_spi_slave_endpoint.sv
// Bench for spi_slave_endpoint: a mode-0 master drives frames, a word-level
// model predicts received words, MISO words and pulse counts.
module tb_spi_slave_endpoint;

   localparam int DATA_W  = 8;
   localparam int SYNC_ST = 2;
   localparam int HALF    = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              sclk, csn, mosi, miso;
   logic [DATA_W-1:0] tx_data, rx_data;
   logic              tx_load, rx_valid, busy, tx_underrun, frame_err;

   always #5 clk = ~clk;

   spi_slave_endpoint #(.DATA_W(DATA_W), .SYNC_ST(SYNC_ST)) dut (
      .clk(clk), .rst(rst),
      .SPI_SCLK(sclk), .SPI_CSN(csn), .SPI_MOSI(mosi), .SPI_MISO(miso),
      .tx_data(tx_data), .tx_load(tx_load),
      .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
      .tx_underrun(tx_underrun), .frame_err(frame_err)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cnt_under = 0;
   int cnt_ferr = 0;

   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] got_q[$];
   logic [DATA_W-1:0] mosi_words[0:3];
   logic [DATA_W-1:0] miso_got[0:3];
   logic [DATA_W-1:0] m_hold;
   bit                m_fresh;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rx_valid) got_q.push_back(rx_data);
      if (tx_underrun) cnt_under++;
      if (frame_err) cnt_ferr++;
   end

   task automatic pulse_load(input logic [DATA_W-1:0] val);
      @(negedge clk);
      tx_data = val;
      tx_load = 1'b1;
      @(negedge clk);
      tx_load = 1'b0;
      m_hold  = val;
      m_fresh = 1'b1;
   endtask

   // Mode-0 master: MOSI changes with SCLK falling, MISO sampled at SCLK rising;
   // CSN is released together with the final SCLK fall.
   task automatic spi_frame(input int nbits);
      for (int w = 0; w < 4; w++) miso_got[w] = '0;
      @(negedge clk);
      csn  = 1'b0;
      mosi = mosi_words[0][DATA_W-1];
      repeat (8) @(negedge clk);
      chk("busy_active", busy, 1);
      for (int i = 0; i < nbits; i++) begin
         mosi = mosi_words[i / DATA_W][DATA_W-1-(i % DATA_W)];
         repeat (HALF) @(negedge clk);
         miso_got[i / DATA_W][DATA_W-1-(i % DATA_W)] = miso;
         sclk = 1'b1;
         repeat (HALF) @(negedge clk);
         sclk = 1'b0;
         if (i == nbits - 1) csn = 1'b1;
      end
      mosi = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   task automatic run_frame(input int nfull, input int extra);
      int under0, ferr0, exp_under, nstarts;
      logic [DATA_W-1:0] exp_miso;
      under0    = cnt_under;
      ferr0     = cnt_ferr;
      exp_under = 0;
      exp_miso  = m_hold;
      got_q.delete();
      for (int w = 0; w < nfull; w++) exp_q.push_back(mosi_words[w]);
      nstarts = nfull + ((extra > 0) ? 1 : 0);
      for (int k = 0; k < nstarts; k++) begin
         if (!m_fresh) exp_under++;
         m_fresh = 1'b0;
      end
      spi_frame(nfull * DATA_W + extra);
      chk("rx_count", got_q.size(), exp_q.size());
      while (exp_q.size() > 0 && got_q.size() > 0)
         chk("rx_data", got_q.pop_front(), exp_q.pop_front());
      exp_q.delete();
      got_q.delete();
      chk("underrun_pulses", cnt_under - under0, exp_under);
      chk("frame_err_pulses", cnt_ferr - ferr0, (extra > 0) ? 1 : 0);
      for (int w = 0; w < nfull; w++) chk("miso_word", miso_got[w], exp_miso);
      chk("busy_idle", busy, 0);
      chk("miso_idle", miso, 0);
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_rx_data"}, rx_data, 0);
      chk({tag, "_rx_valid"}, rx_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_underrun"}, tx_underrun, 0);
      chk({tag, "_frame_err"}, frame_err, 0);
      chk({tag, "_miso"}, miso, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ferr0, nfull, extra;
      rst = 1'b1; csn = 1'b1; sclk = 1'b0; mosi = 1'b0;
      tx_data = '0; tx_load = 1'b0;
      m_hold = '0; m_fresh = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_zero_outputs("reset");

      // receive 0xAA
      pulse_load(8'h00);
      mosi_words[0] = 8'hAA;
      run_frame(1, 0);

      // transmit 0xC3
      pulse_load(8'hC3);
      mosi_words[0] = 8'h3C;
      run_frame(1, 0);

      // two words, only first loaded
      pulse_load(8'hE7);
      mosi_words[0] = 8'h55;
      mosi_words[1] = 8'h0F;
      run_frame(2, 0);

      // partial word then a clean frame
      pulse_load(8'h12);
      mosi_words[0] = 8'hF0;
      run_frame(0, 5);
      pulse_load(8'h9A);
      mosi_words[0] = 8'h5A;
      run_frame(1, 0);

      // reset in the middle of a word
      ferr0 = cnt_ferr;
      got_q.delete();
      @(negedge clk);
      csn = 1'b0; mosi = 1'b1;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         repeat (HALF) @(negedge clk);
         sclk = 1'b1;
         repeat (HALF) @(negedge clk);
         sclk = 1'b0;
      end
      rst = 1'b1; csn = 1'b1; mosi = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      m_hold = '0; m_fresh = 1'b0;
      repeat (6) @(negedge clk);
      check_zero_outputs("midrst");
      chk("midrst_rx_count", got_q.size(), 0);
      chk("midrst_frame_err", cnt_ferr - ferr0, 0);
      pulse_load(8'h3C);
      mosi_words[0] = 8'h81;
      run_frame(1, 0);
      chk("midrst_rx_data_hold", rx_data, 8'h81);

      // randomized frames
      for (int f = 0; f < 20; f++) begin
         nfull = $urandom_range(1, 3);
         extra = ($urandom_range(0, 4) == 0) ? $urandom_range(1, DATA_W - 1) : 0;
         if ($urandom_range(0, 1) == 1) pulse_load(DATA_W'($urandom_range(0, 255)));
         for (int w = 0; w < 4; w++) mosi_words[w] = DATA_W'($urandom_range(0, 255));
         run_frame(nfull, extra);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
